// File: rtl/airlock_pkg.sv
// Shared types and constants for the airlock controller: state encoding,
// counter width and default pump/alarm durations.
package airlock_pkg;

    localparam int CNT_W            = 8;
    localparam int DEF_EVAC_CYCLES  = 4;
    localparam int DEF_FILL_CYCLES  = 3;
    localparam int DEF_ALARM_CYCLES = 8;

    typedef enum logic [2:0] {
        PRESS_IDLE = 3'd0,
        EVAC       = 3'd1,
        VAC_IDLE   = 3'd2,
        FILL       = 3'd3,
        FAULT      = 3'd7
    } state_t;

    function automatic logic is_pump(input state_t s);
        return (s == EVAC) || (s == FILL);
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// Pump duration counter: holds at zero while cleared, counts while enabled,
// and flags the cycle in which the count equals the terminal value.
import airlock_pkg::*;

module airlock_timer (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = en && (count == term);

endmodule

// File: rtl/airlock_controller.sv
// Airlock sequencer with door interlock and latched fault.
// Optional door-held-open alarm enabled by defining AIRLOCK_DOOR_ALARM_EN.
import airlock_pkg::*;

module airlock_controller #(
    parameter int EVAC_CYCLES  = DEF_EVAC_CYCLES,
    parameter int FILL_CYCLES  = DEF_FILL_CYCLES,
    parameter int ALARM_CYCLES = DEF_ALARM_CYCLES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       OuterReq,
    input  logic       InnerReq,
    input  logic       OuterOpen,
    input  logic       InnerOpen,
    output logic       OuterUnlock,
    output logic       InnerUnlock,
    output logic       Evac,
    output logic       Fill,
    output logic       Fault,
    output logic       DoorAlarm,
    output logic [2:0] State
);

    if (EVAC_CYCLES < 1 || EVAC_CYCLES > 255) begin : g_bad_evac
        $error("EVAC_CYCLES must be in 1..255");
    end
    if (FILL_CYCLES < 1 || FILL_CYCLES > 255) begin : g_bad_fill
        $error("FILL_CYCLES must be in 1..255");
    end
    if (ALARM_CYCLES < 1 || ALARM_CYCLES > 255) begin : g_bad_alarm
        $error("ALARM_CYCLES must be in 1..255");
    end

    localparam logic [CNT_W-1:0] EVAC_TERM = CNT_W'(EVAC_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_TERM = CNT_W'(FILL_CYCLES - 1);

    state_t state, state_next;
    logic   pend_outer, pend_outer_next;
    logic   pend_inner, pend_inner_next;
    logic   doors_closed;
    logic   want_outer, want_inner;
    logic   pump_on, pump_clr, pump_done;
    logic [CNT_W-1:0] pump_term;

    assign doors_closed = !OuterOpen && !InnerOpen;
    // A live request and a remembered one are the same condition.
    assign want_outer   = OuterReq || pend_outer;
    assign want_inner   = InnerReq || pend_inner;

    // Clearing on done as well as outside pump states guarantees a fresh
    // count on every pump entry, even back-to-back.
    assign pump_on   = is_pump(state);
    assign pump_clr  = !pump_on || pump_done;
    assign pump_term = (state == FILL) ? FILL_TERM : EVAC_TERM;

    airlock_timer u_timer (
        .clk  (Clock),
        .rst  (Reset),
        .clr  (pump_clr),
        .en   (pump_on),
        .term (pump_term),
        .done (pump_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= PRESS_IDLE;
            pend_outer <= 1'b0;
            pend_inner <= 1'b0;
        end else begin
            state      <= state_next;
            pend_outer <= pend_outer_next;
            pend_inner <= pend_inner_next;
        end
    end

    // Fault checks come first in every branch so they beat requests and
    // counter completion.
    always_comb begin
        state_next      = state;
        pend_outer_next = pend_outer;
        pend_inner_next = pend_inner;
        case (state)
            PRESS_IDLE: begin
                if (OuterOpen) begin
                    state_next = FAULT;
                end else if (want_outer && doors_closed) begin
                    state_next      = EVAC;
                    pend_outer_next = 1'b0;
                end else if (OuterReq) begin
                    pend_outer_next = 1'b1;
                end
            end
            EVAC: begin
                if (InnerReq) begin
                    pend_inner_next = 1'b1;
                end
                if (!doors_closed) begin
                    state_next = FAULT;
                end else if (pump_done) begin
                    state_next = VAC_IDLE;
                end
            end
            VAC_IDLE: begin
                if (InnerOpen) begin
                    state_next = FAULT;
                end else if (want_inner && doors_closed) begin
                    state_next      = FILL;
                    pend_inner_next = 1'b0;
                end else if (InnerReq) begin
                    pend_inner_next = 1'b1;
                end
            end
            FILL: begin
                if (OuterReq) begin
                    pend_outer_next = 1'b1;
                end
                if (!doors_closed) begin
                    state_next = FAULT;
                end else if (pump_done) begin
                    state_next = PRESS_IDLE;
                end
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    always_comb begin
        OuterUnlock = 1'b0;
        InnerUnlock = 1'b0;
        Evac        = 1'b0;
        Fill        = 1'b0;
        Fault       = 1'b0;
        case (state)
            PRESS_IDLE: InnerUnlock = 1'b1;
            EVAC:       Evac        = 1'b1;
            VAC_IDLE:   OuterUnlock = 1'b1;
            FILL:       Fill        = 1'b1;
            default:    Fault       = 1'b1;
        endcase
    end

    assign State = state;

`ifdef AIRLOCK_DOOR_ALARM_EN
    localparam logic [CNT_W-1:0] ALARM_TERM = CNT_W'(ALARM_CYCLES);

    logic [CNT_W-1:0] alarm_cnt;
    logic             free_door_open;

    // The unlocked door is the inner one at pressure, the outer one at vacuum.
    always_comb begin
        free_door_open = 1'b0;
        case (state)
            PRESS_IDLE: free_door_open = InnerOpen;
            VAC_IDLE:   free_door_open = OuterOpen;
            default:    free_door_open = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            alarm_cnt <= '0;
        end else if (!free_door_open || (state_next != state)) begin
            alarm_cnt <= '0;
        end else if (alarm_cnt != '1) begin
            alarm_cnt <= alarm_cnt + 1'b1;
        end
    end

    assign DoorAlarm = (alarm_cnt >= ALARM_TERM);
`else
    assign DoorAlarm = 1'b0;
`endif

endmodule

// File: tb/tb_airlock_controller.sv
// Bench for airlock_controller: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the airlock.
module tb_airlock_controller;

    localparam int EVAC_N  = 4;
    localparam int FILL_N  = 3;
    localparam int ALARM_N = 8;

    // Spec state codes
    localparam int S_PRESS = 0;
    localparam int S_EVAC  = 1;
    localparam int S_VAC   = 2;
    localparam int S_FILL  = 3;
    localparam int S_FAULT = 7;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       OuterReq = 1'b0;
    logic       InnerReq = 1'b0;
    logic       OuterOpen = 1'b0;
    logic       InnerOpen = 1'b0;
    logic       OuterUnlock, InnerUnlock, Evac, Fill, Fault, DoorAlarm;
    logic [2:0] State;

    airlock_controller #(
        .EVAC_CYCLES  (EVAC_N),
        .FILL_CYCLES  (FILL_N),
        .ALARM_CYCLES (ALARM_N)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .OuterReq    (OuterReq),
        .InnerReq    (InnerReq),
        .OuterOpen   (OuterOpen),
        .InnerOpen   (InnerOpen),
        .OuterUnlock (OuterUnlock),
        .InnerUnlock (InnerUnlock),
        .Evac        (Evac),
        .Fill        (Fill),
        .Fault       (Fault),
        .DoorAlarm   (DoorAlarm),
        .State       (State)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode, pump cycles remaining, remembered requests,
    // cycles the free door has been open.
    int m_mode  = S_PRESS;
    int m_left  = 0;
    bit m_po    = 1'b0;
    bit m_pi    = 1'b0;
    int m_alarm = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int expected_outs(input int mode, input int alarm_cycles);
        int o;
        case (mode)
            S_PRESS: o = 6'b010000;
            S_EVAC:  o = 6'b001000;
            S_VAC:   o = 6'b100000;
            S_FILL:  o = 6'b000100;
            default: o = 6'b000010;
        endcase
`ifdef AIRLOCK_DOOR_ALARM_EN
        if (alarm_cycles >= ALARM_N) o = o | 1;
`else
        if (alarm_cycles < 0) o = o | 1;
`endif
        return o;
    endfunction

    task automatic model_update();
        int  cur;
        int  nxt;
        bit  closed;
        bit  free_open;
        if (Reset) begin
            m_mode = S_PRESS; m_left = 0; m_po = 0; m_pi = 0; m_alarm = 0;
            return;
        end
        cur    = m_mode;
        nxt    = m_mode;
        closed = !OuterOpen && !InnerOpen;
        case (cur)
            S_PRESS: begin
                if (OuterOpen) nxt = S_FAULT;
                else if ((OuterReq || m_po) && closed) begin
                    nxt = S_EVAC; m_po = 0; m_left = EVAC_N;
                end else if (OuterReq) m_po = 1;
            end
            S_EVAC: begin
                if (InnerReq) m_pi = 1;
                if (!closed) nxt = S_FAULT;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) nxt = S_VAC;
                end
            end
            S_VAC: begin
                if (InnerOpen) nxt = S_FAULT;
                else if ((InnerReq || m_pi) && closed) begin
                    nxt = S_FILL; m_pi = 0; m_left = FILL_N;
                end else if (InnerReq) m_pi = 1;
            end
            S_FILL: begin
                if (OuterReq) m_po = 1;
                if (!closed) nxt = S_FAULT;
                else begin
                    m_left = m_left - 1;
                    if (m_left == 0) nxt = S_PRESS;
                end
            end
            default: nxt = S_FAULT;
        endcase
        free_open = (cur == S_PRESS && InnerOpen) || (cur == S_VAC && OuterOpen);
        if (free_open && nxt == cur) m_alarm = (m_alarm < 255) ? m_alarm + 1 : 255;
        else m_alarm = 0;
        m_mode = nxt;
    endtask

    task automatic step(input string tag);
        int outs;
        @(posedge Clock);
        model_update();
        #1;
        outs = {26'd0, OuterUnlock, InnerUnlock, Evac, Fill, Fault, DoorAlarm};
        check({tag, "_state"}, int'(State), m_mode);
        check({tag, "_outs"}, outs, expected_outs(m_mode, m_alarm));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        int fl;

        Reset = 1'b1;
        step("rst");
        check("rst_state", int'(State), 0);
        check("rst_inner_unlock", int'(InnerUnlock), 1);
        Reset = 1'b0;

        // One-cycle outer request pumps down for EVAC_N cycles
        OuterReq = 1'b1;
        step("evac_req");
        OuterReq = 1'b0;
        check("evac_enter", int'(State), 1);
        ev = int'(Evac);
        for (int i = 0; i < 8; i++) begin
            step("evac_run");
            ev += int'(Evac);
        end
        check("evac_len", ev, 4);
        check("evac_vac_state", int'(State), 2);
        check("evac_outer_unlock", int'(OuterUnlock), 1);

        // Inner request waits while the outer door is open
        InnerReq  = 1'b1;
        OuterOpen = 1'b1;
        for (int i = 0; i < 5; i++) step("fill_wait");
        check("fill_wait_state", int'(State), 2);
        OuterOpen = 1'b0;
        step("fill_close");
        InnerReq = 1'b0;
        check("fill_enter", int'(State), 3);
        fl = int'(Fill);
        for (int i = 0; i < 6; i++) begin
            step("fill_run");
            fl += int'(Fill);
        end
        check("fill_len", fl, 3);
        check("fill_press_state", int'(State), 0);
        check("fill_inner_unlock", int'(InnerUnlock), 1);

        // Outer request during FILL: one cycle of PRESS_IDLE then EVAC
        OuterReq = 1'b1;
        step("cyc_evac");
        OuterReq = 1'b0;
        for (int i = 0; i < 4; i++) step("cyc_evac_run");
        check("cyc_vac", int'(State), 2);
        InnerReq = 1'b1;
        step("cyc_fill");
        InnerReq = 1'b0;
        check("cyc_fill_state", int'(State), 3);
        step("cyc_fill_c1");
        OuterReq = 1'b1;
        step("cyc_fill_c2");
        OuterReq = 1'b0;
        step("cyc_fill_c3");
        check("pend_press_once", int'(State), 0);
        step("pend_to_evac");
        check("pend_evac", int'(State), 1);

        // Inner door opens on the 2nd EVAC cycle: latched fault until reset
        step("flt_evac_c1");
        InnerOpen = 1'b1;
        step("flt_open");
        InnerOpen = 1'b0;
        check("flt_state", int'(State), 7);
        check("flt_outs", int'({OuterUnlock, InnerUnlock, Evac, Fill, Fault}), 5'b00001);
        OuterReq = 1'b1;
        InnerReq = 1'b1;
        for (int i = 0; i < 3; i++) step("flt_hold");
        OuterReq = 1'b0;
        InnerReq = 1'b0;
        check("flt_absorb", int'(State), 7);
        Reset = 1'b1;
        step("flt_reset");
        Reset = 1'b0;
        check("flt_reset_state", int'(State), 0);
        check("flt_reset_unlock", int'(InnerUnlock), 1);

        // Both requests in PRESS_IDLE: inner request is not remembered
        OuterReq = 1'b1;
        InnerReq = 1'b1;
        step("both_req");
        OuterReq = 1'b0;
        InnerReq = 1'b0;
        check("both_evac", int'(State), 1);
        for (int i = 0; i < 7; i++) step("both_run");
        check("both_no_pend_inner", int'(State), 2);

        // Free door held open in PRESS_IDLE
        Reset = 1'b1;
        step("alm_reset");
        Reset = 1'b0;
        InnerOpen = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step("alm_open");
            if (i == 7) check("alm_before", int'(DoorAlarm), 0);
            if (i == 8) begin
`ifdef AIRLOCK_DOOR_ALARM_EN
                check("alm_rise", int'(DoorAlarm), 1);
`else
                check("alm_tied", int'(DoorAlarm), 0);
`endif
            end
        end
        InnerOpen = 1'b0;
        step("alm_close");
        check("alm_clear", int'(DoorAlarm), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Reset    = (m_mode == S_FAULT) ? ($urandom_range(0, 5) == 0)
                                           : ($urandom_range(0, 299) == 0);
            OuterReq = ($urandom_range(0, 3) == 0);
            InnerReq = ($urandom_range(0, 3) == 0);
            if (OuterOpen) OuterOpen = ($urandom_range(0, 3) != 0);
            else           OuterOpen = ($urandom_range(0, 24) == 0);
            if (InnerOpen) InnerOpen = ($urandom_range(0, 3) != 0);
            else           InnerOpen = ($urandom_range(0, 24) == 0);
            if (m_mode == S_PRESS && $urandom_range(0, 9) == 0) begin
                InnerOpen = 1'b1;
                OuterOpen = 1'b0;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/airlock_controller.md
AIRLOCK_CONTROLLER -- requirements
Module: airlock_controller

Interface
REQ-001 Parameter EVAC_CYCLES, default 4: evacuation pump duration in cycles, legal range 1..255.
REQ-002 Parameter FILL_CYCLES, default 3: fill pump duration in cycles, legal range 1..255.
REQ-003 Parameter ALARM_CYCLES, default 8: door-open alarm threshold in cycles, legal range 1..255.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 OuterReq  input  1  level request to bring the chamber to vacuum (outer side access).
REQ-007 InnerReq  input  1  level request to bring the chamber to pressure (inner side access).
REQ-008 OuterOpen, InnerOpen  input  1 each  door sensors; 1 = open.
REQ-009 OuterUnlock, InnerUnlock  output  1 each  door release.
REQ-010 Evac, Fill  output  1 each  pump drives.
REQ-011 Fault  output  1  latched interlock violation.
REQ-012 DoorAlarm  output  1  door held open too long.
REQ-013 State  output  3  current state encoding.

Function
REQ-014 States SHALL be PRESS_IDLE, EVAC, VAC_IDLE, FILL, FAULT.
REQ-015 Outputs SHALL be Moore, decoded from the state register only: PRESS_IDLE gives InnerUnlock=1; EVAC gives Evac=1; VAC_IDLE gives OuterUnlock=1; FILL gives Fill=1; FAULT gives Fault=1; every other output is 0.
REQ-016 Pending flag pendOuter SHALL be set when OuterReq=1 in PRESS_IDLE or FILL; OuterReq SHALL be ignored in other states.
REQ-017 Pending flag pendInner SHALL be set when InnerReq=1 in VAC_IDLE or EVAC; InnerReq SHALL be ignored in other states.
REQ-018 Request level and pending flag SHALL be treated as one condition; a request sampled at edge N SHALL be able to change State at edge N.
REQ-019 PRESS_IDLE to EVAC SHALL occur when (OuterReq or pendOuter) and OuterOpen=0 and InnerOpen=0; entering EVAC SHALL clear pendOuter.
REQ-020 VAC_IDLE to FILL SHALL occur when (InnerReq or pendInner) and both doors are closed; entering FILL SHALL clear pendInner.
REQ-021 A pending request with a door open SHALL wait in its idle state, stay pending, and fire on the first cycle both doors are closed.
REQ-022 Evac SHALL be high for exactly EVAC_CYCLES consecutive cycles, then the block SHALL enter VAC_IDLE.
REQ-023 Fill SHALL be high for exactly FILL_CYCLES consecutive cycles, then the block SHALL enter PRESS_IDLE.
REQ-024 The cycle counter SHALL clear on pump-state entry and count 0..N-1, with the exit edge at count N-1.
REQ-025 Any door open during EVAC or FILL SHALL force FAULT on the next edge.
REQ-026 The locked door reading open in an idle state SHALL force FAULT on the next edge; the locked door is OuterOpen in PRESS_IDLE and InnerOpen in VAC_IDLE.
REQ-027 FAULT SHALL be absorbing and be left only by Reset.
REQ-028 A fault condition SHALL take priority over any simultaneous request or counter completion.
REQ-029 If pendOuter is set during FILL, PRESS_IDLE SHALL last one cycle when doors are closed, then go to EVAC.

Reset
REQ-030 Reset SHALL force, at the next edge, State=PRESS_IDLE, counter=0, pendOuter=pendInner=0, and alarm counter=0.
REQ-031 After reset the outputs SHALL be InnerUnlock=1 and all other outputs 0.
REQ-032 Reset SHALL override every other input, including mid-pump operation and FAULT.

Configuration
REQ-033 With macro AIRLOCK_DOOR_ALARM_EN defined, an 8-bit alarm counter SHALL count cycles in which the unlocked door is open in an idle state.
REQ-034 Under AIRLOCK_DOOR_ALARM_EN, the alarm counter SHALL saturate, clear when that door closes or the state changes, and drive DoorAlarm=1 while count >= ALARM_CYCLES.
REQ-035 Without AIRLOCK_DOOR_ALARM_EN, DoorAlarm SHALL be tied 0, no alarm counter logic SHALL exist, and the port SHALL remain.

Structure
REQ-036 Package airlock_pkg SHALL hold the state enum with encodings PRESS_IDLE=0, EVAC=1, VAC_IDLE=2, FILL=3, FAULT=7, the 8-bit count width constant, and the default cycle constants.
REQ-037 Sub-module airlock_timer SHALL provide the pump counter: clear and enable inputs, terminal-count input, and a done output.

Verification
REQ-038 Reset, then OuterReq pulse for 1 cycle with doors closed -> Evac high exactly 4 cycles, then OuterUnlock=1, State=2.
REQ-039 From VAC_IDLE, InnerReq held while OuterOpen=1 for 5 cycles, then OuterOpen=0 -> FILL entered on the closing edge, Fill high 3 cycles, then InnerUnlock=1.
REQ-040 InnerOpen=1 on the 2nd cycle of EVAC -> Fault=1, all other outputs 0, held until Reset, then State=0 and InnerUnlock=1.
REQ-041 OuterReq asserted in the 2nd cycle of FILL -> PRESS_IDLE lasts 1 cycle, then EVAC.
REQ-042 With AIRLOCK_DOOR_ALARM_EN defined, InnerOpen=1 in PRESS_IDLE for 10 cycles -> DoorAlarm rises after the 8th cycle and clears the cycle after the door closes; without the macro DoorAlarm stays 0.
REQ-043 OuterReq and InnerReq both high in PRESS_IDLE -> EVAC, and pendInner stays 0.
